// File: rtl/uart_command_rx.sv
// uart_command_rx: UART receiver for the usb_rx line. Deserialises 8N1 frames
// (8E1 when UART_RX_EVEN_PARITY_EN is defined) and turns single-byte ASCII
// commands into one-cycle pulses for the stopwatch counters.
//
// Ports:
//   clk         board clock
//   rst         asynchronous active-high reset
//   rx          serial line, idle high, asynchronous to clk
//   data        last good byte received
//   data_valid  one-cycle pulse, data updated this cycle
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, even-parity mismatch (tied 0 without macro)
//   cmd_start   one-cycle pulse with data_valid for 'S' / 's'
//   cmd_stop    one-cycle pulse with data_valid for 'P' / 'p'
//   cmd_clear   one-cycle pulse with data_valid for 'R' / 'r'
//
// Configuration macro: UART_RX_EVEN_PARITY_EN (adds the parity bit state).
module uart_command_rx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_clear
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_EVEN_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             cmd_start_q, cmd_start_d;
    logic             cmd_stop_q, cmd_stop_d;
    logic             cmd_clear_q, cmd_clear_d;
    logic             rx_meta_q, rx_sync_q;
`ifdef UART_RX_EVEN_PARITY_EN
    logic             perr_q, perr_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser, preset to the idle level so reset is not a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_d        = bit_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cmd_start_d  = 1'b0;
        cmd_stop_d   = 1'b0;
        cmd_clear_d  = 1'b0;
`ifdef UART_RX_EVEN_PARITY_EN
        perr_d       = perr_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_EVEN_PARITY_EN
                perr_d = 1'b0;
`endif
                if (!rx_sync_q) state_d = S_START;
            end
            S_START: begin
                // Mid-start-bit check rejects short glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_EVEN_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_EVEN_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = rx_sync_q ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
`ifdef UART_RX_EVEN_PARITY_EN
                    else if (perr_q) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end
`endif
                    else begin
                        data_valid_d = 1'b1;
                        data_d       = shift_q;
                        state_d      = S_IDLE;
                        case (shift_q)
                            8'h53, 8'h73: cmd_start_d = 1'b1;
                            8'h50, 8'h70: cmd_stop_d  = 1'b1;
                            8'h52, 8'h72: cmd_clear_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            S_BREAK: begin
                // A held-low line reports one frame error, then waits for idle.
                cnt_d = '0;
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cmd_start_q  <= 1'b0;
            cmd_stop_q   <= 1'b0;
            cmd_clear_q  <= 1'b0;
`ifdef UART_RX_EVEN_PARITY_EN
            perr_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            cmd_start_q  <= cmd_start_d;
            cmd_stop_q   <= cmd_stop_d;
            cmd_clear_q  <= cmd_clear_d;
`ifdef UART_RX_EVEN_PARITY_EN
            perr_q       <= perr_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign cmd_start  = cmd_start_q;
    assign cmd_stop   = cmd_stop_q;
    assign cmd_clear  = cmd_clear_q;
`ifdef UART_RX_EVEN_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_command_rx.sv
// Testbench for uart_command_rx: table of single frames plus hand-written
// sequences for glitch, break, back-to-back and mid-frame reset.
module tb_uart_command_rx;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned BAUD        = 1_000_000;
    localparam int unsigned CPB         = CLK_FREQ_HZ / BAUD;
`ifdef UART_RX_EVEN_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    // rx drive -> synced edge (2) + half bit + data/parity/stop + output register
    localparam int unsigned EXP_LAT = 2 + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_valid, frame_err, parity_err;
    logic       cmd_start, cmd_stop, cmd_clear;

    uart_command_rx #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
        .frame_err(frame_err), .parity_err(parity_err), .cmd_start(cmd_start),
        .cmd_stop(cmd_stop), .cmd_clear(cmd_clear)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts high cycles of every pulse and logs data_valid events.
    int unsigned dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, cs_cnt = 0, cp_cnt = 0, cc_cnt = 0, viol_cnt = 0;
    int unsigned ev_cyc [64];
    logic [7:0]  ev_data[64];
    logic [2:0]  ev_cmd [64];

    always @(negedge clk) begin
        if (data_valid) begin
            if (dv_cnt < 64) begin
                ev_cyc[dv_cnt]  = cyc;
                ev_data[dv_cnt] = data;
                ev_cmd[dv_cnt]  = {cmd_start, cmd_stop, cmd_clear};
            end
            dv_cnt++;
        end
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
        if (cmd_start)  cs_cnt++;
        if (cmd_stop)   cp_cnt++;
        if (cmd_clear)  cc_cnt++;
        if (($countones({cmd_start, cmd_stop, cmd_clear}) > 1) ||
            ((cmd_start | cmd_stop | cmd_clear) && !data_valid))
            viol_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    int unsigned start_cyc;

    // Drives one frame from a posedge+1 alignment and returns aligned at the
    // end of the stop bit with rx left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
`ifdef UART_RX_EVEN_PARITY_EN
        rx = (^b) ^ pflip;
        repeat (CPB) @(posedge clk);
        #1;
`else
        if (pflip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       pflip;
        logic       exp_dv;
        logic       exp_fe;
        logic       exp_pe;
        logic [7:0] exp_data;
        logic [2:0] exp_cmd;   // {start, stop, clear}
    } vec_t;

    function automatic vec_t mk(input logic [7:0] b, input logic stop, input logic pflip,
                                input logic dv, input logic fe, input logic pe,
                                input logic [7:0] d, input logic [2:0] cmd);
        vec_t v;
        v.b = b; v.stop = stop; v.pflip = pflip; v.exp_dv = dv; v.exp_fe = fe;
        v.exp_pe = pe; v.exp_data = d; v.exp_cmd = cmd;
        return v;
    endfunction

    vec_t vecs[16];
    int   n_tab;

    initial begin
        int unsigned b_dv, b_fe, b_pe, b_cs, b_cp, b_cc;

        n_tab = 0;
        vecs[n_tab++] = mk(8'h53, 1, 0, 1, 0, 0, 8'h53, 3'b100);
        vecs[n_tab++] = mk(8'h73, 1, 0, 1, 0, 0, 8'h73, 3'b100);
        vecs[n_tab++] = mk(8'h50, 1, 0, 1, 0, 0, 8'h50, 3'b010);
        vecs[n_tab++] = mk(8'h70, 1, 0, 1, 0, 0, 8'h70, 3'b010);
        vecs[n_tab++] = mk(8'h52, 1, 0, 1, 0, 0, 8'h52, 3'b001);
        vecs[n_tab++] = mk(8'h72, 1, 0, 1, 0, 0, 8'h72, 3'b001);
        vecs[n_tab++] = mk(8'h41, 1, 0, 1, 0, 0, 8'h41, 3'b000);
        vecs[n_tab++] = mk(8'hA5, 0, 0, 0, 1, 0, 8'h41, 3'b000);
        vecs[n_tab++] = mk(8'h00, 1, 0, 1, 0, 0, 8'h00, 3'b000);
        vecs[n_tab++] = mk(8'hFF, 1, 0, 1, 0, 0, 8'hFF, 3'b000);
        vecs[n_tab++] = mk(8'h54, 1, 0, 1, 0, 0, 8'h54, 3'b000);
        vecs[n_tab++] = mk(8'h13, 1, 0, 1, 0, 0, 8'h13, 3'b000);
`ifdef UART_RX_EVEN_PARITY_EN
        vecs[n_tab++] = mk(8'h53, 1, 1, 0, 0, 1, 8'h13, 3'b000);
        vecs[n_tab++] = mk(8'h53, 1, 0, 1, 0, 0, 8'h53, 3'b100);
        vecs[n_tab++] = mk(8'h72, 1, 1, 0, 0, 1, 8'h53, 3'b000);
`endif

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("reset_outputs", 32'({data, data_valid, frame_err, parity_err, cmd_start, cmd_stop, cmd_clear}), 32'h0);
        align();
        rst = 1'b0;
        idle(10);

        // Table of single frames
        for (int i = 0; i < n_tab; i++) begin
            b_dv = dv_cnt; b_fe = fe_cnt; b_pe = pe_cnt;
            b_cs = cs_cnt; b_cp = cp_cnt; b_cc = cc_cnt;
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].pflip);
            idle(2 * CPB);
            check($sformatf("v%0d_data_valid", i), dv_cnt - b_dv, 32'(vecs[i].exp_dv));
            check($sformatf("v%0d_frame_err", i),  fe_cnt - b_fe, 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_parity_err", i), pe_cnt - b_pe, 32'(vecs[i].exp_pe));
            check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_cmd", i), 32'({cs_cnt - b_cs, cp_cnt - b_cp, cc_cnt - b_cc}),
                  32'({32'(vecs[i].exp_cmd[2]), 32'(vecs[i].exp_cmd[1]), 32'(vecs[i].exp_cmd[0])}));
            if (vecs[i].exp_dv && (dv_cnt - b_dv) == 1)
                check($sformatf("v%0d_latency", i), ev_cyc[b_dv] - start_cyc, EXP_LAT);
        end

        // Short low glitch: no outputs, receiver still ready
        b_dv = dv_cnt; b_fe = fe_cnt; b_cp = cp_cnt;
        rx = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        idle(3 * CPB);
        check("glitch_no_dv", dv_cnt - b_dv, 0);
        check("glitch_no_fe", fe_cnt - b_fe, 0);
        send_frame(8'h50, 1, 0);
        idle(2 * CPB);
        check("glitch_then_stop_cmd", cp_cnt - b_cp, 1);
        check("glitch_then_data", 32'(data), 32'h50);

        // Bad stop bit followed by a long break: a single frame error
        b_dv = dv_cnt; b_fe = fe_cnt; b_cc = cc_cnt;
        send_frame(8'hA5, 0, 0);
        repeat (2000) @(posedge clk);
        #1;
        check("break_one_fe", fe_cnt - b_fe, 1);
        check("break_no_dv", dv_cnt - b_dv, 0);
        check("break_data_kept", 32'(data), 32'h50);
        idle(2 * CPB);
        send_frame(8'h72, 1, 0);
        idle(2 * CPB);
        check("after_break_clear", cc_cnt - b_cc, 1);
        check("after_break_data", 32'(data), 32'h72);

        // Back-to-back 'p' then 'S' with no idle gap
        b_dv = dv_cnt;
        send_frame(8'h70, 1, 0);
        send_frame(8'h53, 1, 0);
        idle(2 * CPB);
        check("b2b_dv_count", dv_cnt - b_dv, 2);
        if (dv_cnt - b_dv == 2) begin
            check("b2b_spacing", ev_cyc[b_dv + 1] - ev_cyc[b_dv], (10 + PAR_BITS) * CPB);
            check("b2b_first_cmd", 32'(ev_cmd[b_dv]), 32'b010);
            check("b2b_second_cmd", 32'(ev_cmd[b_dv + 1]), 32'b100);
            check("b2b_first_data", 32'(ev_data[b_dv]), 32'h70);
            check("b2b_second_data", 32'(ev_data[b_dv + 1]), 32'h53);
        end

        // Reset after four data bits of 0x52
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = (i == 1 || i == 4) ? 1'b1 : 1'b0;   // 0x52 = 0101_0010, LSB first
            repeat (CPB) @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("midreset_outputs", 32'({data, data_valid, frame_err, parity_err, cmd_start, cmd_stop, cmd_clear}), 32'h0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        b_dv = dv_cnt; b_cs = cs_cnt; b_cp = cp_cnt; b_cc = cc_cnt;
        send_frame(8'h41, 1, 0);
        idle(2 * CPB);
        check("post_reset_dv", dv_cnt - b_dv, 1);
        check("post_reset_data", 32'(data), 32'h41);
        check("post_reset_no_cmd", (cs_cnt - b_cs) + (cp_cnt - b_cp) + (cc_cnt - b_cc), 0);

        // cmd_* always one-hot and only alongside data_valid
        check("cmd_onehot_with_dv", viol_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
